// File: rtl/snap_vacc_capture_ctrl_pkg.sv
// Shared definitions for the vector-accumulator snapshot capture sequencer.
package snap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int ARM_BIT        = 0;
    localparam int TRIG_IMM_BIT   = 1;
    localparam int VALID_GATE_BIT = 2;

    localparam int DONE_BIT = 31;
    localparam int BUSY_BIT = 30;

endpackage

// File: rtl/snap_vacc_capture_ctrl_if.sv
// Control, sample and BRAM-write signals of the snapshot capture sequencer.
interface snap_vacc_capture_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic [31:0]       ctrl_word;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              trig;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status;

    modport master (
        output ctrl_word, din, din_valid, trig,
        input  bram_addr, bram_data, bram_we, status
    );

    modport slave (
        input  ctrl_word, din, din_valid, trig,
        output bram_addr, bram_data, bram_we, status
    );
endinterface

// File: rtl/snap_vacc_capture_ctrl_edge_det.sv
// Registered rising-edge detector; no edge is reported until one real history sample exists.
module snap_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_cur;
    logic r_cur_vld;
    logic r_prev;
    logic r_prev_vld;

    // A level already high when reset releases must not look like a 0->1 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur      <= 1'b0;
            r_cur_vld  <= 1'b0;
            r_prev     <= 1'b0;
            r_prev_vld <= 1'b0;
        end else begin
            r_cur      <= i_d;
            r_cur_vld  <= 1'b1;
            r_prev     <= r_cur;
            r_prev_vld <= r_cur_vld;
        end
    end

    assign o_rise = r_cur & ~r_prev & r_prev_vld;
endmodule

// File: rtl/snap_vacc_capture_ctrl.sv
// Snapshot capture sequencer: arm, trigger, fixed-length burst into BRAM, status readback.
// Optional circular pre-trigger mode is enabled with SNAP_CTRL_PRETRIG_EN.
module snap_vacc_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    snap_vacc_capture_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ARMED   = ST_ARMED;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_DONE    = ST_DONE;

    localparam logic [ADDR_W:0]   FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
`ifdef SNAP_CTRL_PRETRIG_EN
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((1 << (ADDR_W - 1)) - 1);
`endif

    logic              w_arm_edge;
    logic              w_qual;
    logic              w_trig_hit;
    logic              w_capturing;
    logic              w_store;
    logic              w_last;
    logic [ADDR_W:0]   w_count_next;
    logic [31:0]       w_status;
    logic              w_unused_ctrl;

    logic              r_trig_imm;
    logic              r_gate;
    logic              r_dv;
    logic              r_trig;
    logic [DATA_W-1:0] r_din;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              r_busy;
    logic [ADDR_W:0]   r_cnt_stat;
`ifdef SNAP_CTRL_PRETRIG_EN
    logic [ADDR_W-1:0] r_post;
    logic [ADDR_W-1:0] r_trig_addr;
`endif

    snap_edge_det u_arm_edge (
        .clk    (user_clk),
        .rst    (user_rst),
        .i_d    (bus.ctrl_word[ARM_BIT]),
        .o_rise (w_arm_edge)
    );

    assign w_unused_ctrl = ^bus.ctrl_word[31:3];
    assign w_qual        = ~r_gate | r_dv;
    assign w_trig_hit    = r_trig_imm | r_trig;
    assign w_capturing   = ~w_arm_edge & ((r_state == S_CAPTURE) |
                                          ((r_state == S_ARMED) & w_trig_hit));
    assign w_count_next  = (r_count == FULL) ? r_count : r_count + (ADDR_W + 1)'(1);

    // Pre-trigger mode records continuously while armed and ends after half a buffer.
`ifdef SNAP_CTRL_PRETRIG_EN
    assign w_store = ~w_arm_edge & w_qual & ((r_state == S_ARMED) | (r_state == S_CAPTURE));
    assign w_last  = (r_post == POST_LAST);
`else
    assign w_store = w_capturing & w_qual;
    assign w_last  = (r_wptr == LAST);
`endif

    always_comb begin
        w_status               = '0;
        w_status[DONE_BIT]     = r_done;
        w_status[BUSY_BIT]     = r_busy;
        w_status[ADDR_W:0]     = r_cnt_stat;
`ifdef SNAP_CTRL_PRETRIG_EN
        w_status[ADDR_W+15:16] = r_trig_addr;
`endif
    end

    // Input register, sequencer and write/status output stage; an arm edge overrides everything.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_trig_imm  <= 1'b0;
            r_gate      <= 1'b0;
            r_dv        <= 1'b0;
            r_trig      <= 1'b0;
            r_din       <= '0;
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt_stat  <= '0;
`ifdef SNAP_CTRL_PRETRIG_EN
            r_post      <= '0;
            r_trig_addr <= '0;
`endif
        end else begin
            r_trig_imm <= bus.ctrl_word[TRIG_IMM_BIT];
            r_gate     <= bus.ctrl_word[VALID_GATE_BIT];
            r_dv       <= bus.din_valid;
            r_trig     <= bus.trig;
            r_din      <= bus.din;
            r_we       <= 1'b0;
            r_done     <= (r_state == S_DONE) & ~w_arm_edge;
            r_busy     <= w_arm_edge | (r_state == S_ARMED) | (r_state == S_CAPTURE);
            r_cnt_stat <= w_arm_edge ? '0 : r_count;
            if (w_arm_edge) begin
                r_state     <= S_ARMED;
                r_wptr      <= '0;
                r_count     <= '0;
`ifdef SNAP_CTRL_PRETRIG_EN
                r_post      <= '0;
                r_trig_addr <= '0;
`endif
            end else begin
                if ((r_state == S_ARMED) && w_trig_hit) begin
                    r_state     <= S_CAPTURE;
`ifdef SNAP_CTRL_PRETRIG_EN
                    r_trig_addr <= r_wptr;
`endif
                end
                if (w_store) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_wptr;
                    r_data  <= r_din;
                    r_wptr  <= r_wptr + ADDR_W'(1);
                    r_count <= w_count_next;
                    if (w_capturing) begin
`ifdef SNAP_CTRL_PRETRIG_EN
                        r_post <= r_post + ADDR_W'(1);
`endif
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
            end
        end
    end

    assign bus.bram_we   = r_we;
    assign bus.bram_addr = r_addr;
    assign bus.bram_data = r_data;
    assign bus.status    = w_status;
endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Bench for snap_vacc_capture_ctrl at ADDR_W=4: vector table plus hand sequences, writes scored from a queue.
module tb_snap_vacc_capture_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 64;

    logic user_clk = 1'b0;
    logic user_rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] cur_cw;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    typedef struct {
        bit          imm;
        bit          gate;
        int          period;
        int          trig_at;
        int          ncyc;
        logic [31:0] exp_status;
    } vec_t;

    wr_t  expQ[$];
    vec_t vecs[5];

    snap_vacc_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    snap_vacc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) cyc <= cyc + 1;

    // Every strobe must match the oldest expected write, including its arrival cycle.
    always @(negedge user_clk) begin : monitor
        wr_t e;
        if (bus.bram_we === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h at cycle %0d, expected no write",
                         bus.bram_addr, bus.bram_data, cyc);
            end else begin
                e = expQ.pop_front();
                if (bus.bram_addr !== e.addr || bus.bram_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("[TB] FAIL write: got addr %0d data 0x%0h cycle %0d, expected addr %0d data 0x%0h cycle %0d",
                             bus.bram_addr, bus.bram_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] cw, input logic [63:0] d, input logic dv,
                                 input logic tg, input logic exp_store, input logic [ADDR_W-1:0] exp_addr);
        wr_t w;
        bus.ctrl_word = cw;
        bus.din       = d;
        bus.din_valid = dv;
        bus.trig      = tg;
        if (exp_store) begin
            w.addr = exp_addr;
            w.data = d;
            w.cyc  = cyc + 2;
            expQ.push_back(w);
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic armSequence(input bit imm, input bit gate, input bit trig_on_edge);
        applyStimulus(cur_cw & ~32'h1, 64'hDEAD_0000, 1'b0, 1'b0, 1'b0, '0);
        cur_cw = 32'hA5A5_A5A0 | {29'b0, gate, imm, 1'b1};
        applyStimulus(cur_cw, 64'hDEAD_0001, 1'b1, trig_on_edge, 1'b0, '0);
    endtask

    initial begin
        int k;
        bit hit;
        bit tg;
        bit dv;
        bit store;

        vecs[0] = '{1'b1, 1'b0, 1, 0,    20, 32'h8000_0010};
        vecs[1] = '{1'b1, 1'b1, 2, 0,    32, 32'h8000_0010};
        vecs[2] = '{1'b0, 1'b0, 1, 20,   40, 32'h8000_0010};
        vecs[3] = '{1'b1, 1'b1, 3, 0,    30, 32'h4000_000A};
        vecs[4] = '{1'b0, 1'b0, 1, 1000, 25, 32'h4000_0000};

        user_rst      = 1'b1;
        cur_cw        = 32'h0;
        bus.ctrl_word = 32'h0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.trig      = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("reset_we",     bus.bram_we,   0);
        checkOutput("reset_addr",   bus.bram_addr, 0);
        checkOutput("reset_data",   bus.bram_data, 0);
        checkOutput("reset_status", bus.status,    0);
        user_rst = 1'b0;

`ifdef SNAP_CTRL_PRETRIG_EN
        armSequence(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 38; i++) begin
            tg = (i == 30);
            applyStimulus(cur_cw, 64'h400 + 64'(i), 1'b1, tg, 1'b1, ADDR_W'(i));
        end
        repeat (4) applyStimulus(cur_cw, 64'h0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pretrig_status", bus.status, 32'h800E_0010);
        checkOutput("pretrig_drained", expQ.size(), 0);
`else
        for (int v = 0; v < 5; v++) begin
            k   = 0;
            armSequence(vecs[v].imm, vecs[v].gate, !vecs[v].imm);
            hit = vecs[v].imm;
            for (int i = 0; i < vecs[v].ncyc; i++) begin
                tg    = !vecs[v].imm && (i == vecs[v].trig_at);
                hit   = hit | tg;
                dv    = (i % vecs[v].period) == 0;
                store = hit && (!vecs[v].gate || dv) && (k < 16);
                applyStimulus(cur_cw, 64'((v << 8) | i), dv, tg, store, ADDR_W'(k));
                if (store) k++;
                if (!vecs[v].imm && !hit && i == 10) begin
                    checkOutput("busy_while_armed", bus.status[30], 1);
                end
            end
            repeat (4) applyStimulus(cur_cw, 64'h0, 1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("vec%0d_status", v), bus.status, vecs[v].exp_status);
            checkOutput($sformatf("vec%0d_drained", v), expQ.size(), 0);
        end

        // Re-arm mid-capture, with a trigger alongside the arm edge while ARMED.
        armSequence(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(cur_cw, 64'h100 + 64'(i), 1'b1, 1'b0, 1'b1, ADDR_W'(i));
        end
        cur_cw = cur_cw & ~32'h1;
        applyStimulus(cur_cw, 64'h105, 1'b1, 1'b0, 1'b1, 4'd5);
        cur_cw = cur_cw | 32'h1;
        applyStimulus(cur_cw, 64'h106, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(cur_cw, 64'h107, 1'b1, 1'b0, 1'b1, 4'd0);
        checkOutput("rearm_count_cleared", bus.status, 32'h4000_0000);
        for (int j = 1; j < 16; j++) begin
            applyStimulus(cur_cw, 64'h107 + 64'(j), 1'b1, 1'b0, 1'b1, ADDR_W'(j));
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(cur_cw, 64'h200 + 64'(i), 1'b1, 1'b0, 1'b0, '0);
        end
        checkOutput("arm_hold_status", bus.status, 32'h8000_0010);
        checkOutput("arm_hold_drained", expQ.size(), 0);

        // Reset in the middle of a capture after seven writes.
        armSequence(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(cur_cw, 64'h300 + 64'(i), 1'b1, 1'b0, i < 7, ADDR_W'(i));
        end
        user_rst = 1'b1;
        applyStimulus(cur_cw, 64'h308, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("midrst_we",     bus.bram_we,   0);
        checkOutput("midrst_status", bus.status,    0);
        checkOutput("midrst_addr",   bus.bram_addr, 0);
        checkOutput("midrst_data",   bus.bram_data, 0);
        checkOutput("midrst_drained", expQ.size(),  0);
        applyStimulus(cur_cw, 64'h309, 1'b1, 1'b0, 1'b0, '0);
        user_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(cur_cw, 64'h310 + 64'(i), 1'b1, 1'b1, 1'b0, '0);
        end
        checkOutput("post_reset_idle", bus.status, 32'h0);
        armSequence(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(cur_cw, 64'h500 + 64'(i), 1'b1, 1'b0, 1'b1, ADDR_W'(i));
        end
        repeat (4) applyStimulus(cur_cw, 64'h0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("post_reset_capture", bus.status, 32'h8000_0010);
`endif

        checkOutput("final_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snap_vacc_capture_ctrl.md
# snap_vacc_capture_ctrl

Sequencer for a vector-accumulator snapshot capture. It runs in the user clock domain and is driven by the 32-bit software control word from the snapshot control register. It arms on a software edge, waits for a trigger, and writes a fixed-length burst of valid accumulator samples into the snapshot BRAM. Completion and fill count are reported back through a status word for software readout.

## Interface
- ADDR_W, 10, BRAM address width; a capture is at most 2^ADDR_W words.
- DATA_W, 64, sample width.
- user_clk  in  1  sole clock; every register is clocked on its rising edge.
- user_rst  in  1  synchronous, active-high reset.
- ctrl_word  in  32  control register value, quasi-static:
  - bit0 arm: a 0->1 edge starts a capture.
  - bit1 trig_imm: 1 = trigger immediately; 0 = wait for `trig`.
  - bit2 valid_gate: 1 = store only `din_valid` samples; 0 = store every cycle.
  - bits[31:3] ignored.
- din  in  DATA_W  accumulator sample.
- din_valid  in  1  sample qualifier.
- trig  in  1  external trigger, level-sampled.
- bram_addr  out  ADDR_W  write address.
- bram_data  out  DATA_W  write data.
- bram_we  out  1  write strobe.
- status  out  32  status word:
  - bit31 done.
  - bit30 armed_or_capturing.
  - bits[ADDR_W:0] words written.
  - all other bits 0.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED on an arm edge (ctrl_word[0]=1, previous registered value 0); the word count clears to 0.
- ARMED -> CAPTURE when trig_imm=1, or when trig=1 in that cycle. The triggering cycle's sample is stored if it qualifies.
- In CAPTURE, a sample qualifies when valid_gate=0, or when valid_gate=1 and din_valid=1. Each qualifying sample:
  - writes to bram_addr = count;
  - increments count.
- CAPTURE -> DONE when the write at address 2^ADDR_W-1 issues. count saturates at 2^ADDR_W; the address never wraps.
- DONE holds until the next arm edge, which goes to ARMED. done clears in the same cycle as that edge.
- An arm edge while in ARMED or CAPTURE restarts the capture: state -> ARMED, count=0, and no write occurs in that cycle.
- The arm level held at 1 produces no further edges. Software must write 0 and then 1 to re-arm.
- trig, din and din_valid are ignored outside ARMED and CAPTURE.

## Timing
- Inputs are registered once, so:
  - bram_we/addr/data appear 2 cycles after the qualifying din/din_valid;
  - the state transition takes effect 1 cycle after the arm edge or trigger is registered.
- status updates in the cycle after the corresponding write strobe. Exception: done is set in the cycle after the last bram_we.
- Reset values:
  - state IDLE;
  - bram_we 0;
  - bram_addr 0;
  - bram_data 0;
  - status 0;
  - arm history register 0, so an arm bit already at 1 after reset is not an edge.
- Reset mid-capture aborts immediately; no write issues in the cycle after reset.
- Arm edge and trig in the same cycle: the arm edge wins, state -> ARMED, and the trigger is discarded.
- Throughput: one write per cycle, sustained.

## Configuration
- SNAP_CTRL_PRETRIG_EN defined: circular pre-trigger mode.
  - ARMED writes qualifying samples continuously, and the address wraps modulo 2^ADDR_W.
  - On trigger, the trigger address is latched into status[ADDR_W+15:16].
  - CAPTURE then stores 2^(ADDR_W-1) further samples before DONE.
  - The count field reports total writes, saturating at 2^ADDR_W.
- SNAP_CTRL_PRETRIG_EN undefined:
  - ARMED never writes;
  - status[ADDR_W+15:16] is tied to 0;
  - behaviour is exactly as described above.

## Structure
- Shared package snap_ctrl_pkg holds:
  - the state enum;
  - control bit index constants (ARM_BIT=0, TRIG_IMM_BIT=1, VALID_GATE_BIT=2);
  - status bit constants (DONE_BIT=31, BUSY_BIT=30).
- One sub-module: snap_edge_det, a registered rising-edge detector used for arm.
- Everything else stays in one always block with a registered output stage.

## Test plan
- Immediate capture, ADDR_W=4: arm edge with trig_imm=1 and valid_gate=0, ramp din = 0..15 -> addresses 0..15 hold 0..15, done=1, count=16, no 17th write.
- Gated capture: valid_gate=1, din_valid every other cycle -> 16 writes over 32 cycles, consecutive addresses, only valid samples stored.
- External trigger: trig_imm=0, trig pulses 20 cycles after arm -> no bram_we before the trigger, first stored word is the trigger-cycle sample, status bit30=1 throughout.
- Re-arm mid-capture: arm 0->1 after 5 writes -> count returns to 0, next write at address 0; an arm held high for 100 cycles produces no re-arm.
- Reset: user_rst asserted during CAPTURE at count=7 -> next cycle status=0, bram_we=0, state IDLE; a later arm edge runs a full capture.
- SNAP_CTRL_PRETRIG_EN defined, ADDR_W=4: 30 samples before the trigger, then trigger -> 8 post-trigger writes, trigger address latched correctly, address wraps 15->0, count=16.
